// File: rtl/calc_mem_pkg.sv
// Shared definitions for the calculator's saved-number history memory.
// Used by both the save path and the recall reader.
package calc_mem_pkg;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 8;
  localparam int ADDR_W   = $clog2(DEPTH);
  localparam int READ_LAT = 1;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/mem_recall_reader.sv
// Read side of the history memory. Each accepted okRECALL issues one RAM
// read; successive recalls walk from the newest entry back to the oldest and
// then wrap to the newest again. A save event restarts the walk.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous reset, active low
//   okRECALL      recall request pulse
//   save_evt      save path wrote a new entry
//   wr_ptr        save path's next write index (newest = wr_ptr-1)
//   count         number of valid entries, 0..DEPTH
//   rd_en         RAM read strobe, one cycle per recall
//   rd_addr       RAM read address, held from issue through capture
//   rd_data       RAM read data, valid READ_LAT cycles after rd_en
//   recall_num    recalled value, held until replaced
//   recall_valid  recall_num is current
//   recall_empty  one-cycle pulse: request made with an empty history
//   busy          read in flight
//
// state | meaning
// IDLE  | waiting for a recall request
// ISSUE | rd_en asserted, address presented to the RAM
// WAIT  | counting down the RAM read latency, capture on the last cycle
module mem_recall_reader #(
  parameter int DATA_W   = calc_mem_pkg::DATA_W,
  parameter int DEPTH    = calc_mem_pkg::DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int READ_LAT = calc_mem_pkg::READ_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              okRECALL,
  input  logic              save_evt,
  input  logic [ADDR_W-1:0] wr_ptr,
  input  logic [ADDR_W:0]   count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] recall_num,
  output logic              recall_valid,
  output logic              recall_empty,
  output logic              busy
);
  import calc_mem_pkg::*;

  localparam int LAT_W = $clog2(READ_LAT + 1);

  rd_state_t         state, state_next;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W:0]   offset_inc;
  logic [LAT_W-1:0]  lat_cnt;
  logic              accept;
  logic              capture;
  logic              empty_req;

  assign accept     = (state == IDLE) && okRECALL && !save_evt && (count != '0);
  assign empty_req  = (state == IDLE) && okRECALL && !save_evt && (count == '0);
  assign capture    = (state == WAIT) && (lat_cnt == LAT_W'(1)) && !save_evt;
  assign offset_inc = {1'b0, offset} + (ADDR_W+1)'(1);

  assign rd_en = (state == ISSUE);
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (lat_cnt == LAT_W'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // A save aborts any read in flight; its data is never captured.
    if (save_evt) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr      <= '0;
      offset       <= '0;
      lat_cnt      <= '0;
      recall_num   <= '0;
      recall_valid <= 1'b0;
      recall_empty <= 1'b0;
    end else begin
      recall_empty <= empty_req;

      if (accept) begin
        // Modular subtraction: wr_ptr=0 naturally wraps to the top entry.
        rd_addr      <= wr_ptr - offset - ADDR_W'(1);
        recall_valid <= 1'b0;
      end

      if (state == ISSUE)
        lat_cnt <= LAT_W'(READ_LAT);
      else if (state == WAIT && lat_cnt != '0)
        lat_cnt <= lat_cnt - LAT_W'(1);

      if (capture) begin
        recall_num   <= rd_data;
        recall_valid <= 1'b1;
        // >= rather than == so a history that shrank under us restarts at
        // the newest entry instead of walking past the valid range.
        if (offset_inc >= count) offset <= '0;
        else                     offset <= offset_inc[ADDR_W-1:0];
      end

      if (save_evt) begin
        offset       <= '0;
        recall_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_recall_reader.sv
module tb_mem_recall_reader;
  import calc_mem_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              okRECALL = 1'b0;
  logic              save_evt = 1'b0;
  logic [ADDR_W-1:0] wr_ptr = '0;
  logic [ADDR_W:0]   count = '0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data = '0;
  logic [DATA_W-1:0] recall_num;
  logic              recall_valid;
  logic              recall_empty;
  logic              busy;

  logic [DATA_W-1:0] mem [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position in the newest-to-oldest walk and last recall.
  int                m_offset = 0;
  logic [DATA_W-1:0] m_num = '0;
  logic              m_valid = 1'b0;

  mem_recall_reader dut (
    .clk(clk), .rst_n(rst_n), .okRECALL(okRECALL), .save_evt(save_evt),
    .wr_ptr(wr_ptr), .count(count), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .recall_num(recall_num), .recall_valid(recall_valid),
    .recall_empty(recall_empty), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural RAM, one-cycle read latency.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int newest_minus(int ofs);
    return ((int'(wr_ptr) - 1 - ofs) % DEPTH + DEPTH) % DEPTH;
  endfunction

  function automatic void model_capture(int addr);
    m_num    = mem[addr];
    m_valid  = 1'b1;
    m_offset = (m_offset + 1 >= int'(count)) ? 0 : m_offset + 1;
  endfunction

  // Full recall with cycle-exact latency checks: request in cycle k,
  // rd_en in k+1, recall_valid from k+3.
  task automatic do_recall(input string tag);
    int exp_addr;
    exp_addr = newest_minus(m_offset);
    okRECALL = 1'b1;
    tick();
    okRECALL = 1'b0;
    check({tag, "_rd_en"}, rd_en, 1);
    check({tag, "_rd_addr"}, rd_addr, exp_addr);
    check({tag, "_busy_issue"}, busy, 1);
    check({tag, "_valid_clr"}, recall_valid, 0);
    tick();
    check({tag, "_rd_en_once"}, rd_en, 0);
    check({tag, "_valid_wait"}, recall_valid, 0);
    tick();
    model_capture(exp_addr);
    check({tag, "_valid"}, recall_valid, 1);
    check({tag, "_num"}, recall_num, m_num);
    check({tag, "_busy_done"}, busy, 0);
  endtask

  task automatic do_save(input string tag);
    save_evt = 1'b1;
    tick();
    save_evt = 1'b0;
    m_offset = 0;
    m_valid  = 1'b0;
    check({tag, "_valid"}, recall_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_num_hold"}, recall_num, m_num);
  endtask

  initial begin
    int rd_pulses;
    int exp_addr;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    // 1. Reset with all inputs driven high
    okRECALL = 1'b1; save_evt = 1'b1; wr_ptr = '1; count = (ADDR_W+1)'(DEPTH);
    repeat (3) tick();
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_num", recall_num, 0);
    check("rst_valid", recall_valid, 0);
    check("rst_empty", recall_empty, 0);
    check("rst_busy", busy, 0);
    okRECALL = 1'b0; save_evt = 1'b0; wr_ptr = '0; count = '0;
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", recall_valid, 0);
    check("post_rst_rd_en", rd_en, 0);

    // 2. Empty history
    okRECALL = 1'b1;
    tick();
    okRECALL = 1'b0;
    check("empty_pulse", recall_empty, 1);
    check("empty_rd_en", rd_en, 0);
    check("empty_busy", busy, 0);
    check("empty_valid", recall_valid, 0);
    tick();
    check("empty_pulse_end", recall_empty, 0);
    check("empty_rd_en2", rd_en, 0);

    // 3. Three entries, walk newest to oldest and wrap
    mem[0] = 8'd10; mem[1] = 8'd20; mem[2] = 8'd30;
    wr_ptr = 3'd3; count = 4'd3;
    do_recall("walk0"); check("walk0_addr_abs", rd_addr, 2); check("walk0_val_abs", recall_num, 30);
    do_recall("walk1"); check("walk1_addr_abs", rd_addr, 1); check("walk1_val_abs", recall_num, 20);
    do_recall("walk2"); check("walk2_addr_abs", rd_addr, 0); check("walk2_val_abs", recall_num, 10);
    do_recall("walk3"); check("walk3_addr_abs", rd_addr, 2); check("walk3_val_abs", recall_num, 30);

    // 4. Address wraps below zero
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(100 + i);
    wr_ptr = 3'd1; count = 4'd8;
    do_save("wrap_save");
    do_recall("wrap0"); check("wrap0_addr_abs", rd_addr, 0);
    do_recall("wrap1"); check("wrap1_addr_abs", rd_addr, 7);

    // 5. Save while waiting for read data
    okRECALL = 1'b1;
    tick();
    okRECALL = 1'b0;
    tick();
    check("abort_in_wait", busy, 1);
    save_evt = 1'b1;
    tick();
    save_evt = 1'b0;
    m_offset = 0; m_valid = 1'b0;
    check("abort_valid", recall_valid, 0);
    check("abort_num_hold", recall_num, m_num);
    check("abort_busy", busy, 0);
    do_recall("after_abort"); check("after_abort_addr_abs", rd_addr, 0);

    // 6. Simultaneous save drops request; requests while busy are ignored
    okRECALL = 1'b1; save_evt = 1'b1;
    tick();
    okRECALL = 1'b0; save_evt = 1'b0;
    m_offset = 0; m_valid = 1'b0;
    check("coll_rd_en", rd_en, 0);
    check("coll_busy", busy, 0);
    check("coll_empty", recall_empty, 0);
    exp_addr = newest_minus(m_offset);
    rd_pulses = 0;
    okRECALL = 1'b1;
    tick();
    rd_pulses += int'(rd_en);
    check("busy_req_addr", rd_addr, exp_addr);
    tick();
    rd_pulses += int'(rd_en);
    okRECALL = 1'b0;
    tick();
    rd_pulses += int'(rd_en);
    model_capture(exp_addr);
    check("busy_req_num", recall_num, m_num);
    check("busy_req_valid", recall_valid, 1);
    repeat (3) begin
      tick();
      rd_pulses += int'(rd_en);
    end
    check("busy_req_pulses", rd_pulses, 1);

    // Randomized mix of recalls, saves and history shrinkage
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        0, 1: begin
          mem[wr_ptr] = DATA_W'($urandom);
          wr_ptr = wr_ptr + 1'b1;
          if (int'(count) < DEPTH) count = count + 1'b1;
          do_save("rnd_save");
        end
        2: begin
          count = (ADDR_W+1)'($urandom_range(1, DEPTH));
          tick();
        end
        default: begin
          if (count == '0) count = (ADDR_W+1)'(1);
          do_recall("rnd_recall");
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
